// File: rtl/ddr_rw_arbiter_pkg.sv
// ddr_rw_arbiter_pkg: shared FSM state and grant encodings for the DDR read/write arbiter
package ddr_rw_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, AW, W, AR, R} state_t;
  typedef enum logic {GRANT_WR, GRANT_RD} grant_t;
endpackage

// File: rtl/ddr_rw_arbiter_wr_skid_buf.sv
// ddr_rw_arbiter_wr_skid_buf: 2-entry buffer absorbing the 1-cycle write-FIFO read latency against wready
module ddr_rw_arbiter_wr_skid_buf #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            occ
);
  logic [DATA_WIDTH-1:0] e0, e1;
  assign valid = occ != 2'd0;
  assign dout = e0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      occ <= '0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      occ <= occ + 2'(push) - 2'(pop);
      if (pop) e0 <= (occ == 2'd2) ? e1 : din;
      else if (push && occ == 2'd0) e0 <= din;
      if (push && (occ == 2'd2 || (occ == 2'd1 && !pop))) e1 <= din;
    end
endmodule

// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter: grants one AXI port to whole write or read bursts over a DDR ring buffer
module ddr_rw_arbiter
  import ddr_rw_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int BURST_LEN = 16,
  parameter int LEVEL_WIDTH = 11,
  parameter int RFIFO_DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_END = 28'h0100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_done,
  input  logic                   rd_req_en,
  input  logic [LEVEL_WIDTH-1:0] wfifo_level,
  output logic                   wfifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  wfifo_rd_data,
  input  logic [LEVEL_WIDTH-1:0] rfifo_level,
  output logic                   rfifo_wr_en,
  output logic [DATA_WIDTH-1:0]  rfifo_wr_data,
  output logic [ADDR_WIDTH-1:0]  axi_awaddr,
  output logic [7:0]             axi_awlen,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [DATA_WIDTH-1:0]  axi_wdata,
  output logic                   axi_wlast,
  output logic                   axi_wvalid,
  input  logic                   axi_wready,
  output logic [ADDR_WIDTH-1:0]  axi_araddr,
  output logic [7:0]             axi_arlen,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [DATA_WIDTH-1:0]  axi_rdata,
  input  logic                   axi_rlast,
  input  logic                   axi_rvalid,
  output logic                   axi_rready,
  output logic                   busy,
  output logic                   beat_err
);
  localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] A_STEP = ADDR_WIDTH'(BURST_BYTES);
  localparam int RING_BURSTS = int'((ADDR_END - ADDR_BASE) / A_STEP);
  localparam int FW = $clog2(RING_BURSTS + 1);
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(RING_BURSTS);
  localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0] B_LEN = BW'(BURST_LEN);
  localparam logic [LEVEL_WIDTH-1:0] LV_BURST = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [LEVEL_WIDTH-1:0] LV_RMAX = LEVEL_WIDTH'(RFIFO_DEPTH - BURST_LEN);
  state_t state, state_nx;
  grant_t last_grant;
  logic [FW-1:0] fill;
  logic [BW-1:0] popped, wbeat, rbeat;
  logic inflight, sk_valid, wr_ok, rd_ok, w_pop, w_done, r_done;
  logic [1:0] occ;
  function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] a);
    nxt = (a + A_STEP == ADDR_END) ? ADDR_BASE : a + A_STEP;
  endfunction
  ddr_rw_arbiter_wr_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk(clk), .rst(rst), .push(inflight), .din(wfifo_rd_data), .pop(w_pop),
    .valid(sk_valid), .dout(axi_wdata), .occ(occ)
  );
  assign axi_awlen = 8'(BURST_LEN - 1);
  assign axi_arlen = 8'(BURST_LEN - 1);
  always_comb begin
    wr_ok = init_done && wfifo_level >= LV_BURST && fill < FILL_MAX;
    rd_ok = init_done && rd_req_en && fill != '0 && rfifo_level <= LV_RMAX;
    busy = state != IDLE;
    axi_awvalid = state == AW;
    axi_wvalid = state == W && sk_valid;
    axi_wlast = wbeat == B_LAST;
    w_pop = axi_wvalid && axi_wready;
    w_done = w_pop && axi_wlast;
    axi_arvalid = state == AR;
    axi_rready = state == R;
    rfifo_wr_en = axi_rready && axi_rvalid;
    rfifo_wr_data = axi_rdata;
    r_done = rfifo_wr_en && axi_rlast;
    // counting this cycle's pop keeps a steady 1 beat/clk with only 2 entries
    wfifo_rd_en = (state == AW || state == W) && popped < B_LEN &&
                  ({1'b0, occ} + {2'b0, inflight} - {2'b0, w_pop}) < 3'd2;
    state_nx = state;
    case (state)
      IDLE: state_nx = (wr_ok && (!rd_ok || last_grant == GRANT_RD)) ? AW : rd_ok ? AR : IDLE;
      AW: state_nx = axi_awready ? W : AW;
      W: state_nx = w_done ? IDLE : W;
      AR: state_nx = axi_arready ? R : AR;
      R: state_nx = r_done ? IDLE : R;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last_grant <= GRANT_RD;
      fill <= '0;
      axi_awaddr <= ADDR_BASE;
      axi_araddr <= ADDR_BASE;
      popped <= '0;
      wbeat <= '0;
      rbeat <= '0;
      inflight <= 1'b0;
      beat_err <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= wfifo_rd_en;
      popped <= busy ? popped + BW'(wfifo_rd_en) : '0;
      wbeat <= busy ? wbeat + BW'(w_pop) : '0;
      rbeat <= busy ? rbeat + BW'(rfifo_wr_en) : '0;
      if (!busy && state_nx != IDLE) last_grant <= (state_nx == AW) ? GRANT_WR : GRANT_RD;
      if (w_done) axi_awaddr <= nxt(axi_awaddr);
      if (r_done) axi_araddr <= nxt(axi_araddr);
      if (w_done) fill <= fill + FW'(1);
      else if (r_done) fill <= fill - FW'(1);
      if (rfifo_wr_en && (axi_rlast != (rbeat == B_LAST))) beat_err <= 1'b1;
    end
endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb_ddr_rw_arbiter: randomized scoreboard bench with a ring-buffer model and an AXI memory slave
module tb_ddr_rw_arbiter;
  logic clk = 1'b0;
  logic tb_rst, init_done, rd_req_en;
  logic [10:0] wfifo_level, rfifo_level;
  logic wfifo_rd_en, rfifo_wr_en;
  logic [127:0] wfifo_rd_data, rfifo_wr_data, axi_wdata, axi_rdata;
  logic [27:0] axi_awaddr, axi_araddr;
  logic [7:0] axi_awlen, axi_arlen;
  logic axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic busy, beat_err;
  int errors = 0, checks = 0;
  int mode = 0, err_cnt = 0, err_done = 0;
  int m_wptr = 0, m_rptr = 0, m_fill = 0, m_last = 2, pend = 0, m_wbeat = 0, pops_since = 0, total = 0;
  bit pend_v = 0;
  logic [127:0] wexp[$], rexp[$];
  logic [127:0] mem[int];

  always #5 clk = ~clk;

  ddr_rw_arbiter #(.ADDR_END(28'h400)) dut (
    .clk(clk), .rst(tb_rst), .init_done(init_done), .rd_req_en(rd_req_en),
    .wfifo_level(wfifo_level), .wfifo_rd_en(wfifo_rd_en), .wfifo_rd_data(wfifo_rd_data),
    .rfifo_level(rfifo_level), .rfifo_wr_en(rfifo_wr_en), .rfifo_wr_data(rfifo_wr_data),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .busy(busy), .beat_err(beat_err)
  );

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // write-FIFO source and AXI memory slave; expectations are queued as data is issued
  initial begin
    bit s_rd, s_ar, s_r, tog;
    logic [27:0] s_araddr;
    bit r_act;
    int r_beat, r_end, r_base, r;
    logic [31:0] seq;
    wfifo_rd_data = '0; axi_rdata = '0; axi_rvalid = 0; axi_rlast = 0;
    axi_awready = 1; axi_arready = 1; axi_wready = 1; rfifo_level = '0;
    tog = 0; seq = 0; r_act = 0; r_beat = 0; r_end = 15; r_base = 0;
    forever begin
      @(negedge clk);
      s_rd = wfifo_rd_en; s_ar = axi_arvalid && axi_arready; s_r = axi_rvalid && axi_rready;
      s_araddr = axi_araddr;
      @(posedge clk); #1;
      tog = !tog;
      axi_awready = (mode == 1) ? 1'($urandom % 2) : 1'b1;
      axi_arready = (mode == 1) ? 1'($urandom % 2) : 1'b1;
      axi_wready = (mode == 1) ? ($urandom % 4 != 0) : (mode == 2) ? tog : 1'b1;
      r = $urandom % 4;
      rfifo_level = (mode != 1) ? 11'd0 : (r == 0) ? 11'd1008 : (r == 1) ? 11'd1009 : 11'($urandom % 1009);
      if (tb_rst) begin
        r_act = 0; axi_rvalid = 0; axi_rlast = 0;
      end else begin
        if (s_rd) begin
          seq++;
          wfifo_rd_data = {seq, $urandom, $urandom, $urandom};
          wexp.push_back(wfifo_rd_data);
        end
        if (s_r) begin
          if (r_beat == r_end) r_act = 0;
          else r_beat++;
        end
        if (s_ar) begin
          r_act = 1; r_base = int'(s_araddr); r_beat = 0;
          r_end = (err_done < err_cnt) ? 9 : 15;
          if (err_done < err_cnt) err_done++;
        end
        axi_rvalid = r_act && (mode != 1 || $urandom % 3 != 0);
        axi_rlast = axi_rvalid && r_beat == r_end;
        if (axi_rvalid) begin
          axi_rdata = mem[r_base + r_beat * 16];
          rexp.push_back(axi_rdata);
        end
      end
    end
  end

  // monitor: ring model (pointers, fill, round-robin) and data scoreboard
  always @(negedge clk) begin
    bit wr_ok, rd_ok;
    logic [127:0] e;
    if (tb_rst) begin
      m_wptr = 0; m_rptr = 0; m_fill = 0; m_last = 2; pend_v = 0; m_wbeat = 0; pops_since = 0;
      wexp.delete(); rexp.delete();
    end else begin
      if (pend_v) begin
        chk("grant_aw", axi_awvalid, pend == 1);
        chk("grant_ar", axi_arvalid, pend == 2);
        if (pend != 0) m_last = pend;
      end
      pend_v = !busy;
      if (!busy) begin
        wr_ok = init_done && wfifo_level >= 16 && m_fill < 4;
        rd_ok = init_done && rd_req_en && m_fill > 0 && rfifo_level <= 1008;
        pend = (wr_ok && rd_ok) ? ((m_last == 1) ? 2 : 1) : wr_ok ? 1 : rd_ok ? 2 : 0;
      end
      if (wfifo_rd_en) pops_since++;
      if (axi_awvalid && axi_awready) begin
        chk("awaddr", axi_awaddr, m_wptr);
        chk("awlen", axi_awlen, 15);
        chk("aw_ring_not_full", m_fill < 4, 1);
      end
      if (axi_wvalid && axi_wready) begin
        e = wexp.size() ? wexp.pop_front() : 'x;
        chk("wdata", axi_wdata, e);
        chk("wlast", axi_wlast, m_wbeat == 15);
        mem[m_wptr + m_wbeat * 16] = axi_wdata;
        m_wbeat++;
        if (axi_wlast) begin
          chk("pops_per_burst", pops_since, 16);
          pops_since = 0; m_wbeat = 0;
          m_wptr = (m_wptr + 256) % 1024; m_fill++; total++;
        end
      end
      if (axi_arvalid && axi_arready) begin
        chk("araddr", axi_araddr, m_rptr);
        chk("arlen", axi_arlen, 15);
        chk("ar_ring_not_empty", m_fill > 0, 1);
      end
      if (axi_rvalid) begin
        e = rexp.size() ? rexp.pop_front() : 'x;
        chk("rready", axi_rready, 1);
        chk("rfifo_wr_en", rfifo_wr_en, 1);
        chk("rfifo_wr_data", rfifo_wr_data, e);
        if (axi_rlast) begin
          m_rptr = (m_rptr + 256) % 1024; m_fill--; total++;
        end
      end
    end
  end

  task automatic run_bursts(input int n);
    int tgt = total + n, c = 0;
    while (total < tgt && c < 5000) begin @(negedge clk); c++; end
    chk("burst_timeout", total >= tgt, 1);
  endtask

  task automatic wait_busy(input bit v, input string nm);
    int c = 0;
    while (busy !== v && c < 3000) begin @(negedge clk); c++; end
    chk(nm, busy, v);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 tb_rst = 1;
    repeat (2) @(posedge clk);
    #1 tb_rst = 0;
  endtask

  initial begin
    int c;
    bit seen;
    tb_rst = 1; init_done = 0; rd_req_en = 0; wfifo_level = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_awaddr", axi_awaddr, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_beat_err", beat_err, 0);
    tb_rst = 0;
    // single write burst
    init_done = 1; wfifo_level = 16;
    c = 0;
    while (!axi_awvalid && c < 200) begin @(negedge clk); c++; end
    chk("first_aw_seen", axi_awvalid, 1);
    @(posedge clk); #1 wfifo_level = 0;
    run_bursts(1);
    repeat (3) @(negedge clk);
    chk("next_awaddr", axi_awaddr, 28'h100);
    chk("idle_after_write", busy, 0);
    // interleaved writes and reads
    rd_req_en = 1; wfifo_level = 64;
    run_bursts(6);
    // ring full, then wrap
    rd_req_en = 0; wfifo_level = 100;
    do_reset();
    run_bursts(4);
    repeat (30) @(negedge clk);
    chk("ring_full_stall", busy, 0);
    chk("awaddr_wrap", axi_awaddr, 0);
    @(posedge clk); #1 rd_req_en = 1;
    run_bursts(2);
    // wready toggling
    mode = 2;
    run_bursts(8);
    // short read burst
    mode = 0;
    chk("beat_err_clear", beat_err, 0);
    err_cnt = 1;
    c = 0;
    while (err_done < 1 && c < 3000) begin @(negedge clk); c++; end
    chk("err_burst_issued", err_done, 1);
    wait_busy(0, "idle_after_short_read");
    chk("beat_err_set", beat_err, 1);
    run_bursts(4);
    chk("beat_err_sticky", beat_err, 1);
    // init_done drop mid-burst
    mode = 1;
    wait_busy(1, "busy_before_init_drop");
    @(posedge clk); #1 init_done = 0;
    wait_busy(0, "burst_completes_init_low");
    seen = 0;
    repeat (20) begin @(negedge clk); if (busy) seen = 1; end
    chk("no_grant_init_low", seen, 0);
    @(posedge clk); #1 init_done = 1;
    // reset mid-W burst
    run_bursts(2);
    c = 0;
    while (!(axi_wvalid && m_wbeat >= 5) && c < 3000) begin @(negedge clk); c++; end
    chk("mid_w_reached", axi_wvalid, 1);
    #2 tb_rst = 1;
    #1;
    chk("arst_awvalid", axi_awvalid, 0);
    chk("arst_wvalid", axi_wvalid, 0);
    chk("arst_arvalid", axi_arvalid, 0);
    chk("arst_rd_en", wfifo_rd_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_awaddr", axi_awaddr, 0);
    chk("arst_araddr", axi_araddr, 0);
    chk("arst_beat_err", beat_err, 0);
    wfifo_level = 0;
    @(posedge clk); @(posedge clk);
    #1 tb_rst = 0;
    seen = 0;
    repeat (20) begin @(negedge clk); if (axi_arvalid) seen = 1; end
    chk("empty_ring_no_read", seen, 0);
    @(posedge clk); #1 wfifo_level = 64;
    run_bursts(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
